// File: rtl/reloj_bcd_sync.sv
// reloj_bcd_sync: single-clock BCD time-of-day clock (HH:MM:SS).
//
// A prescaler derives a one-cycle 1 Hz tick from clk. Two buttons are
// synchronised and edge-detected:
//   - set advances the set FSM RUN -> SET_M0 -> SET_M1 -> SET_H -> RUN.
//   - P0 increments the field currently being set.
// Hours are stored as 24-hour BCD. The 12/24-hour conversion and the
// field blinking are display-only decodes of the registered state.
//
// Ports:
//   clk     master clock
//   rst     asynchronous reset, active-high
//   P0      increment button (asynchronous)
//   set     mode-advance button (asynchronous)
//   mode12  1 = 12-hour display, 0 = 24-hour display
//   S0/S1   seconds units/tens (BCD)
//   M0/M1   minutes units/tens (BCD)
//   H0/H1   hours units/tens (BCD)
//   Dots    colon, 1 Hz with 50 % duty
//   pm      1 when the stored hour is 12 or later
//   sel     FSM state code
module reloj_bcd_sync #(
    parameter int unsigned CLK_HZ   = 1000000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       P0,
    input  logic       set,
    input  logic       mode12,
    output logic [3:0] S0,
    output logic [2:0] S1,
    output logic [3:0] M0,
    output logic [3:0] M1,
    output logic [3:0] H0,
    output logic [1:0] H1,
    output logic       Dots,
    output logic       pm,
    output logic [1:0] sel
);

    localparam int unsigned BlinkHalf = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PcW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BcW       = (BlinkHalf > 1) ? $clog2(BlinkHalf) : 1;
    localparam logic [PcW-1:0] PcMax  = PcW'(CLK_HZ - 1);
    localparam logic [PcW-1:0] PcHalf = PcW'(CLK_HZ / 2);
    localparam logic [BcW-1:0] BcMax  = BcW'(BlinkHalf - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StSetM0 = 2'd1,
        StSetM1 = 2'd2,
        StSetH  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [BcW-1:0] bc_q, bc_d;
    logic           blink_q, blink_d;
    // [0] first sync stage, [1] second sync stage, [2] edge-detect history
    logic [2:0]     p0_sync_q, p0_sync_d;
    logic [2:0]     set_sync_q, set_sync_d;
    logic [3:0]     s0_q, s0_d;
    logic [2:0]     s1_q, s1_d;
    logic [3:0]     m0_q, m0_d;
    logic [2:0]     m1_q, m1_d;
    logic [3:0]     h0_q, h0_d;
    logic [1:0]     h1_q, h1_d;

    logic       tick;
    logic       p0_edge;
    logic       set_edge;
    logic [3:0] h0_inc;
    logic [1:0] h1_inc;

    assign tick     = (pc_q == PcMax);
    assign p0_edge  = p0_sync_q[1] & ~p0_sync_q[2];
    assign set_edge = set_sync_q[1] & ~set_sync_q[2];

    // Hour increment with 23 -> 00 wrap, shared by RUN carry and SET_H.
    always_comb begin
        h0_inc = h0_q + 4'd1;
        h1_inc = h1_q;
        if (h1_q == 2'd2 && h0_q == 4'd3) begin
            h0_inc = 4'd0;
            h1_inc = 2'd0;
        end else if (h0_q == 4'd9) begin
            h0_inc = 4'd0;
            h1_inc = h1_q + 2'd1;
        end
    end

    always_comb begin
        pc_d       = tick ? '0 : pc_q + PcW'(1);
        bc_d       = (bc_q == BcMax) ? '0 : bc_q + BcW'(1);
        blink_d    = (bc_q == BcMax) ? ~blink_q : blink_q;
        p0_sync_d  = {p0_sync_q[1:0], P0};
        set_sync_d = {set_sync_q[1:0], set};
        state_d    = state_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        m0_d       = m0_q;
        m1_d       = m1_q;
        h0_d       = h0_q;
        h1_d       = h1_q;

        if (set_edge) begin
            // set wins over a simultaneous P0 edge or tick.
            unique case (state_q)
                StRun: begin
                    state_d = StSetM0;
                    s0_d    = 4'd0;
                    s1_d    = 3'd0;
                end
                StSetM0: state_d = StSetM1;
                StSetM1: state_d = StSetH;
                StSetH: begin
                    state_d = StRun;
                    pc_d    = '0;
                end
                default: state_d = StRun;
            endcase
        end else if (state_q == StRun) begin
            if (tick) begin
                s0_d = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
                if (s0_q == 4'd9) begin
                    s1_d = (s1_q == 3'd5) ? 3'd0 : s1_q + 3'd1;
                    if (s1_q == 3'd5) begin
                        m0_d = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
                        if (m0_q == 4'd9) begin
                            m1_d = (m1_q == 3'd5) ? 3'd0 : m1_q + 3'd1;
                            if (m1_q == 3'd5) begin
                                h0_d = h0_inc;
                                h1_d = h1_inc;
                            end
                        end
                    end
                end
            end
        end else if (p0_edge) begin
            unique case (state_q)
                StSetM0: m0_d = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
                StSetM1: m1_d = (m1_q == 3'd5) ? 3'd0 : m1_q + 3'd1;
                StSetH: begin
                    h0_d = h0_inc;
                    h1_d = h1_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= '0;
            bc_q       <= '0;
            blink_q    <= 1'b0;
            p0_sync_q  <= '0;
            set_sync_q <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            m0_q       <= '0;
            m1_q       <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bc_q       <= bc_d;
            blink_q    <= blink_d;
            p0_sync_q  <= p0_sync_d;
            set_sync_q <= set_sync_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
        end
    end

    // Display decode: 12/24-hour conversion first, then blanking.
    logic [4:0] hour_bin;
    logic [4:0] disp_bin;
    logic [3:0] h0_disp;
    logic [1:0] h1_disp;

    always_comb begin
        hour_bin = ({3'b000, h1_q} * 5'd10) + {1'b0, h0_q};
        disp_bin = hour_bin;
        h0_disp  = h0_q;
        h1_disp  = h1_q;
        if (mode12) begin
            if (hour_bin == 5'd0) begin
                disp_bin = 5'd12;
            end else if (hour_bin > 5'd12) begin
                disp_bin = hour_bin - 5'd12;
            end
            if (disp_bin >= 5'd10) begin
                h1_disp = 2'd1;
                h0_disp = 4'(disp_bin - 5'd10);
            end else begin
                h1_disp = 2'd0;
                h0_disp = disp_bin[3:0];
            end
        end

        S0   = s0_q;
        S1   = s1_q;
        M0   = (blink_q && state_q == StSetM0) ? 4'hF : m0_q;
        M1   = (blink_q && state_q == StSetM1) ? 4'hF : {1'b0, m1_q};
        H0   = (blink_q && state_q == StSetH) ? 4'hF : h0_disp;
        H1   = (blink_q && state_q == StSetH) ? 2'b11 : h1_disp;
        Dots = (pc_q < PcHalf);
        pm   = (hour_bin >= 5'd12);
        sel  = state_q;
    end

endmodule

// File: tb/tb_reloj_bcd_sync.sv
// Directed self-checking bench for reloj_bcd_sync at CLK_HZ=10, BLINK_HZ=1.
// Expected time/state is tracked in integers (eh, em, es, est) and turned
// into expected display values by a small reference model.
module tb_reloj_bcd_sync;

    localparam int unsigned ClkHz   = 10;
    localparam int unsigned BlinkHz = 1;
    localparam int unsigned Half    = ClkHz / (2 * BlinkHz);

    logic       clk = 1'b0;
    logic       rst;
    logic       P0;
    logic       set;
    logic       mode12;
    logic [3:0] S0;
    logic [2:0] S1;
    logic [3:0] M0;
    logic [3:0] M1;
    logic [3:0] H0;
    logic [1:0] H1;
    logic       Dots;
    logic       pm;
    logic [1:0] sel;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int eh, em, es, est;
    logic [23:0] obs, expv;

    reloj_bcd_sync #(
        .CLK_HZ  (ClkHz),
        .BLINK_HZ(BlinkHz)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .P0    (P0),
        .set   (set),
        .mode12(mode12),
        .S0    (S0),
        .S1    (S1),
        .M0    (M0),
        .M1    (M1),
        .H0    (H0),
        .H1    (H1),
        .Dots  (Dots),
        .pm    (pm),
        .sel   (sel)
    );

    always #5 clk = ~clk;

    // Reference display model: {H1,H0,M1,M0,S1,S0}.
    function automatic logic [20:0] model_disp(input int h, input int m, input int s,
                                               input int st, input bit m12, input bit blk);
        int dh;
        logic [1:0] h1;
        logic [3:0] h0, m1, m0, s0;
        logic [2:0] s1;
        dh = h;
        if (m12) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        h1 = 2'(dh / 10);
        h0 = 4'(dh % 10);
        m1 = 4'(m / 10);
        m0 = 4'(m % 10);
        s1 = 3'(s / 10);
        s0 = 4'(s % 10);
        if (blk && st == 1) m0 = 4'hF;
        if (blk && st == 2) m1 = 4'hF;
        if (blk && st == 3) begin
            h1 = 2'b11;
            h0 = 4'hF;
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    // Blink flop is 1 during the second half of every 2*Half-cycle window.
    function automatic bit blink_now();
        return ((cyc / Half) % 2) == 1;
    endfunction

    function automatic logic [23:0] model_all();
        return {model_disp(eh, em, es, est, mode12, blink_now()), 1'(eh >= 12), 2'(est)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_p0();
        P0 = 1'b1;
        step(3);
        P0 = 1'b0;
        step(2);
    endtask

    task automatic pulse_set();
        set = 1'b1;
        step(3);
        set = 1'b0;
        step(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        P0 = 1'b0;
        set = 1'b0;
        mode12 = 1'b0;
        step(1);
        rst = 1'b0;
        cyc = 0;
        eh = 0;
        em = 0;
        es = 0;
        est = 0;
    endtask

    task automatic test_reset();
        logic [1:0] dsel;
        rst = 1'b1;
        P0 = 1'b0;
        set = 1'b0;
        mode12 = 1'b0;
        step(2);
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        dsel = {Dots, 1'b0};
        if (obs !== 24'h0 || dsel !== 2'b10) begin
            $display("FAIL reset_outputs: got %h dots=%b want 000000 dots=1", obs, Dots);
            fails++;
        end
        checks++;
        mode12 = 1'b1;
        #1;
        if ({H1, H0} !== 6'b01_0010) begin
            $display("FAIL reset_mode12_hours: got %b%h want 12", H1, H0);
            fails++;
        end
        checks++;
        mode12 = 1'b0;
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if ({S0, Dots} !== {4'(k / 10), 1'((k % 10) < 5)}) begin
                $display("FAIL run_dots_k%0d: got S0=%h Dots=%b want S0=%0d Dots=%b",
                         k, S0, Dots, k / 10, (k % 10) < 5);
                fails++;
            end
            checks++;
        end
    endtask

    task automatic test_rollover();
        do_reset();
        pulse_set();
        est = 1;
        for (int i = 0; i < 9; i++) begin
            pulse_p0();
            em = em + 1;
        end
        pulse_set();
        est = 2;
        for (int i = 0; i < 5; i++) begin
            pulse_p0();
            em = em + 10;
        end
        pulse_set();
        est = 3;
        for (int i = 0; i < 23; i++) begin
            pulse_p0();
            eh = eh + 1;
            obs = {H1, H0, M1, M0, S1, S0, pm, sel};
            expv = model_all();
            if (obs !== expv) begin
                $display("FAIL preload_hour_%0d: got %h want %h", eh, obs, expv);
                fails++;
            end
            checks++;
        end
        pulse_set();
        est = 0;
        // pc restarted at the accepting edge and has advanced 2 since.
        step(8);
        es = 1;
        step(570);
        es = 58;
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 2; m++) begin
                mode12 = 1'(m);
                #1;
                obs = {H1, H0, M1, M0, S1, S0, pm, sel};
                expv = model_all();
                if (obs !== expv) begin
                    $display("FAIL rollover_s%0d_m12_%0d: got %h want %h", es, m, obs, expv);
                    fails++;
                end
                checks++;
            end
            mode12 = 1'b0;
            step(10);
            es = es + 1;
            if (es == 60) begin
                es = 0;
                em = 0;
                eh = 0;
            end
        end
    endtask

    task automatic test_set_m0();
        do_reset();
        step(27);
        es = 2;
        set = 1'b1;
        step(2);
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL set_before_3rd_edge: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
        // Third edge coincides with a tick: tick discarded, seconds cleared.
        step(1);
        est = 1;
        es = 0;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL set_on_3rd_edge: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
        set = 1'b0;
        step(2);
        for (int i = 1; i <= 11; i++) begin
            pulse_p0();
            em = (em / 10) * 10 + ((em % 10) + 1) % 10;
            obs = {H1, H0, M1, M0, S1, S0, pm, sel};
            expv = model_all();
            if (obs !== expv) begin
                $display("FAIL m0_inc_%0d: got %h want %h", i, obs, expv);
                fails++;
            end
            checks++;
        end
        for (int i = 0; i < 2 * Half; i++) begin
            step(1);
            obs = {H1, H0, M1, M0, S1, S0, pm, sel};
            expv = model_all();
            if (obs !== expv) begin
                $display("FAIL blink_cyc%0d: got %h want %h", cyc, obs, expv);
                fails++;
            end
            checks++;
        end
    endtask

    task automatic test_set_m1_h();
        pulse_set();
        est = 2;
        for (int i = 1; i <= 6; i++) begin
            pulse_p0();
            em = (((em / 10) + 1) % 6) * 10 + em % 10;
            obs = {H1, H0, M1, M0, S1, S0, pm, sel};
            expv = model_all();
            if (obs !== expv) begin
                $display("FAIL m1_inc_%0d: got %h want %h", i, obs, expv);
                fails++;
            end
            checks++;
        end
        pulse_set();
        est = 3;
        for (int i = 1; i <= 24; i++) begin
            pulse_p0();
            eh = (eh + 1) % 24;
            for (int m = 0; m < 2; m++) begin
                mode12 = 1'(m);
                #1;
                obs = {H1, H0, M1, M0, S1, S0, pm, sel};
                expv = model_all();
                if (obs !== expv) begin
                    $display("FAIL h_inc_%0d_m12_%0d: got %h want %h", eh, m, obs, expv);
                    fails++;
                end
                checks++;
            end
            mode12 = 1'b0;
        end
        set = 1'b1;
        step(3);
        est = 0;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv || Dots !== 1'b1) begin
            $display("FAIL exit_set: got %h dots=%b want %h dots=1", obs, Dots, expv);
            fails++;
        end
        checks++;
        set = 1'b0;
        step(5);
        if (Dots !== 1'b0) begin
            $display("FAIL exit_pc_dots: got %b want 0", Dots);
            fails++;
        end
        checks++;
        step(4);
        if (S0 !== 4'd0) begin
            $display("FAIL exit_pc_pretick: got S0=%h want 0", S0);
            fails++;
        end
        checks++;
        step(1);
        es = 1;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL exit_pc_tick: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_p0();
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL p0_in_run: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
        pulse_set();
        est = 1;
        set = 1'b1;
        P0 = 1'b1;
        step(3);
        est = 2;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL set_p0_same_cycle: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
        set = 1'b0;
        P0 = 1'b0;
        step(2);
        P0 = 1'b1;
        step(3);
        em = 10;
        for (int i = 0; i < 2; i++) begin
            obs = {H1, H0, M1, M0, S1, S0, pm, sel};
            expv = model_all();
            if (obs !== expv) begin
                $display("FAIL p0_hold_%0d: got %h want %h", i, obs, expv);
                fails++;
            end
            checks++;
            step(47);
        end
        P0 = 1'b0;
        step(3);
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_set();
        est = 1;
        repeat (2) pulse_p0();
        pulse_set();
        est = 2;
        repeat (4) pulse_p0();
        pulse_set();
        est = 3;
        repeat (15) pulse_p0();
        eh = 15;
        em = 42;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        expv = model_all();
        if (obs !== expv) begin
            $display("FAIL preload_15_42: got %h want %h", obs, expv);
            fails++;
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        obs = {H1, H0, M1, M0, S1, S0, pm, sel};
        if (obs !== 24'h0) begin
            $display("FAIL async_reset: got %h want 000000", obs);
            fails++;
        end
        checks++;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set_m0();
        test_set_m1_h();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
